dcache_dm_wb: RTL
=================

// Module: dcache_dm_wb
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the MEM stage
//  (*_2DC / *_fDC signals) and the block data-memory interface (dBlkRead/dBlkWrite).
//  Replaces the no-cache pass-through and stalls MEM via data_valid_fDC on a miss.
//  Drains all dirty lines and invalidates all lines on flush_2DC, so SYS can
//  proceed with a coherent memory.
// PARAMETERS
//  NUM_LINES   32  line count; power of two, >= 2
//  ADDR_WIDTH  32  byte-address width
//  LINE_BYTES  32  fixed at 32 (256-bit block bus); 8 words per line
// PORTS
//  CLK                    in   1    clock, rising edge
//  RESET                  in   1    asynchronous, active-low reset
//  data_address_2DC       in   32   byte address from MEM
//  read_2DC               in   1    load request, level, held until data_valid_fDC
//  write_2DC              in   1    store request, level, held until data_valid_fDC
//  data_write_2DC         in   32   store data; low N bytes are used
//  data_write_size_2DC    in   2    1/2/3 = bytes, 0 = 4 bytes
//  flush_2DC              in   1    drain and invalidate request, held until flush_done_fDC
//  data_read_fDC          out  32   load word, aligned word containing the address
//  data_valid_fDC         out  1    request completed this cycle
//  flush_done_fDC         out  1    flush finished
//  data_address_2DM       out  32   line-aligned block address to memory
//  dBlkRead               out  1    block read request
//  dBlkWrite              out  1    block write request
//  block_write_2DM        out  256  victim line data, word 0 in [255:224]
//  block_read_fDM         in   256  refill line data, same word order
//  block_read_fDM_valid   in   1    refill data valid this cycle
//  block_write_fDM_valid  in   1    write-back accepted this cycle
// BEHAVIOUR
//  - Address split: offset [4:0]; index [4+log2(NUM_LINES):5]; tag = the remaining upper bits.
//  - Reset (RESET=0), asynchronous: all valid and dirty bits cleared; state = IDLE.
//    All outputs 0, including data_address_2DM and block_write_2DM.
//  - Reset mid-refill or mid-write-back: requests drop immediately and nothing is installed.
//  - States: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
//  - IDLE, hit: data_valid_fDC=1 combinationally in the same cycle (0-cycle latency).
//    A load drives data_read_fDC from the array. A store updates the bytes at the
//    clock edge and sets dirty.
//  - IDLE, miss: data_valid_fDC=0.
//    - Victim valid and dirty: go to WRITEBACK.
//    - Otherwise: go to REFILL.
//  - WRITEBACK: dBlkWrite=1, data_address_2DM = victim {tag,index,5'b0},
//    block_write_2DM = victim line. All three are held stable until
//    block_write_fDM_valid=1 is sampled, then go to REFILL.
//  - REFILL: dBlkRead=1, data_address_2DM = {addr[31:5],5'b0}, held until
//    block_read_fDM_valid=1. Then install the line (valid=1, dirty=0) and return to IDLE.
//    The pending request hits on the next cycle; a store merges after the refill.
//  - Memory handshakes may complete in the same cycle they are raised.
//    dBlkRead and dBlkWrite are never high together.
//  - Store byte lanes, big-endian: byte at offset b = word bits [31-8*(b%4) -: 8].
//    A size-N store at address A writes data_write_2DC[8N-1:0] to bytes A..A+N-1,
//    most significant byte at A.
//    Lanes past the word end are dropped; there is no wrap and no line crossing.
//  - read_2DC and write_2DC both high: treated as a store. data_read_fDC returns
//    the pre-store word.
//  - Flush (flush_2DC=1 in IDLE) has priority over a simultaneous read/write.
//    FLUSH_SCAN walks index 0..NUM_LINES-1, one line per cycle.
//    A dirty line goes through FLUSH_WB with the same handshake as WRITEBACK,
//    then the scan resumes at index+1.
//    After the last index: all valid and dirty bits are cleared and
//    flush_done_fDC=1 is held while flush_2DC stays 1. Return to IDLE when flush_2DC=0.
//  - flush_2DC dropping mid-flush: the flush still completes; flush_done_fDC pulses for 1 cycle.
//  - data_valid_fDC=0 whenever no request is pending or the state is not IDLE.
// TESTING
//  1. Reset, then load 0x1000. Memory returns line {0x11223344,...} 3 cycles after dBlkRead.
//     -> dBlkRead=1 with addr 0x1000 for 3 cycles; valid=0 throughout.
//     -> Next cycle: valid=1, data_read_fDC=0x11223344.
//  2. Following 1: store size=1, data 0xAB, addr 0x1001 (hit).
//     -> Same-cycle valid and no dBlk*; then load 0x1000 returns 0x11AB3344.
//     Also: size=2, data 0xBEEF at 0x1003 -> only byte 3 = 0xBE changes.
//  3. Dirty line at 0x1000 with NUM_LINES=32; load 0x1400 (same index).
//     -> dBlkWrite at 0x1000 carrying the modified line; then dBlkRead at 0x1400.
//     -> Load 0x1000 afterwards misses.
//  4. Lines 0 and 5 dirty, line 7 clean; flush_2DC=1.
//     -> Exactly two dBlkWrite transfers (0x...000 and the index-5 address); flush_done_fDC=1.
//     -> Every later access misses.
//  5. RESET=0 asserted during REFILL while block_read_fDM_valid is still 0.
//     -> dBlkRead=0 immediately; after release, the same load misses again.
//  6. Simultaneous flush_2DC=1 and read_2DC=1 in IDLE.
//     -> No valid until flush_done_fDC; the read is serviced afterwards as a miss.

Source files
------------

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// the 256-bit block data-memory interface.
//
// Ports:
//   CLK, RESET                 clock (rising edge), asynchronous active-low reset
//   data_address_2DC           byte address of the load/store request
//   read_2DC / write_2DC       level requests, held until data_valid_fDC
//   data_write_2DC             store data, low N bytes used
//   data_write_size_2DC        store size in bytes (0 means 4)
//   flush_2DC                  drain dirty lines and invalidate, held until flush_done_fDC
//   data_read_fDC              aligned word containing the request address
//   data_valid_fDC             request completed this cycle (hit in IDLE)
//   flush_done_fDC             flush finished
//   data_address_2DM           line-aligned block address to memory
//   dBlkRead / dBlkWrite       block read / write requests (never both high)
//   block_write_2DM            victim line, word 0 in [255:224]
//   block_read_fDM             refill line, same word order
//   block_read_fDM_valid       refill data valid this cycle
//   block_write_fDM_valid      write-back accepted this cycle
module dcache_dm_wb #(
    parameter int unsigned NUM_LINES  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BYTES = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] data_address_2DC,
    input  logic                  read_2DC,
    input  logic                  write_2DC,
    input  logic [31:0]           data_write_2DC,
    input  logic [1:0]            data_write_size_2DC,
    input  logic                  flush_2DC,
    output logic [31:0]           data_read_fDC,
    output logic                  data_valid_fDC,
    output logic                  flush_done_fDC,
    output logic [ADDR_WIDTH-1:0] data_address_2DM,
    output logic                  dBlkRead,
    output logic                  dBlkWrite,
    output logic [255:0]          block_write_2DM,
    input  logic [255:0]          block_read_fDM,
    input  logic                  block_read_fDM_valid,
    input  logic                  block_write_fDM_valid
);

    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        StIdle,
        StWriteback,
        StRefill,
        StFlushScan,
        StFlushWb
    } state_e;

    state_e state_q, state_d;

    // scan_q[IDX_W] set means every index has been visited and the flush is done.
    logic [IDX_W:0]                scan_q, scan_d;
    logic [ADDR_WIDTH-OFF_W-1:0]   miss_line_q, miss_line_d;
    logic [NUM_LINES-1:0]          valid_q, valid_d;
    logic [NUM_LINES-1:0]          dirty_q, dirty_d;
    logic [255:0]                  data_q [NUM_LINES];
    logic [TAG_W-1:0]              tag_q  [NUM_LINES];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [2:0]       req_word;
    logic [2:0]       word_sel;
    logic [7:0]       word_base;
    logic             req;
    logic             hit;
    logic [255:0]     cur_line;
    logic [31:0]      cur_word;
    logic [31:0]      store_word;
    logic [255:0]     store_line;

    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] wb_idx;
    logic             store_en;
    logic             fill_en;

    assign req_tag   = data_address_2DC[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx   = data_address_2DC[OFF_W +: IDX_W];
    assign req_word  = data_address_2DC[4:2];
    // Word 0 lives in the top 32 bits of the line.
    assign word_sel  = 3'd7 - req_word;
    assign word_base = {word_sel, 5'b0};
    assign req       = read_2DC | write_2DC;
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign cur_line  = data_q[req_idx];
    assign cur_word  = cur_line[word_base +: 32];

    assign miss_idx  = miss_line_q[IDX_W-1:0];
    assign miss_tag  = miss_line_q[IDX_W +: TAG_W];
    assign scan_idx  = scan_q[IDX_W-1:0];
    assign wb_idx    = (state_q == StFlushWb) ? scan_idx : miss_idx;

    // Big-endian byte merge; lanes running past the end of the word are dropped.
    always_comb begin
        int n;
        int o;
        store_word = cur_word;
        n = (data_write_size_2DC == 2'd0) ? 4 : int'(data_write_size_2DC);
        o = int'(data_address_2DC[1:0]);
        for (int k = 0; k < 4; k++) begin
            if ((k < n) && (o + k < 4)) begin
                store_word[8*(3-o-k) +: 8] = data_write_2DC[8*(n-1-k) +: 8];
            end
        end
        store_line = cur_line;
        store_line[word_base +: 32] = store_word;
    end

    always_comb begin
        state_d          = state_q;
        scan_d           = scan_q;
        miss_line_d      = miss_line_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        store_en         = 1'b0;
        fill_en          = 1'b0;
        data_valid_fDC   = 1'b0;
        data_read_fDC    = '0;
        flush_done_fDC   = 1'b0;
        dBlkRead         = 1'b0;
        dBlkWrite        = 1'b0;
        data_address_2DM = '0;
        block_write_2DM  = '0;

        unique case (state_q)
            StIdle: begin
                if (flush_2DC) begin
                    state_d = StFlushScan;
                    scan_d  = '0;
                end else if (req) begin
                    if (hit) begin
                        data_valid_fDC = 1'b1;
                        data_read_fDC  = cur_word;
                        if (write_2DC) begin
                            store_en         = 1'b1;
                            dirty_d[req_idx] = 1'b1;
                        end
                    end else begin
                        miss_line_d = data_address_2DC[ADDR_WIDTH-1:OFF_W];
                        state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? StWriteback
                                                                         : StRefill;
                    end
                end
            end
            StWriteback, StFlushWb: begin
                dBlkWrite        = 1'b1;
                data_address_2DM = {tag_q[wb_idx], wb_idx, {OFF_W{1'b0}}};
                block_write_2DM  = data_q[wb_idx];
                if (block_write_fDM_valid) begin
                    if (state_q == StFlushWb) begin
                        dirty_d[scan_idx] = 1'b0;
                        scan_d            = scan_q + (IDX_W+1)'(1);
                        state_d           = StFlushScan;
                    end else begin
                        state_d = StRefill;
                    end
                end
            end
            StRefill: begin
                dBlkRead         = 1'b1;
                data_address_2DM = {miss_line_q, {OFF_W{1'b0}}};
                if (block_read_fDM_valid) begin
                    fill_en           = 1'b1;
                    valid_d[miss_idx] = 1'b1;
                    dirty_d[miss_idx] = 1'b0;
                    state_d           = StIdle;
                end
            end
            StFlushScan: begin
                if (scan_q[IDX_W]) begin
                    // Done phase: stays here while flush_2DC is held, at least one cycle.
                    flush_done_fDC = 1'b1;
                    valid_d        = '0;
                    dirty_d        = '0;
                    if (!flush_2DC) begin
                        state_d = StIdle;
                    end
                end else if (valid_q[scan_idx] && dirty_q[scan_idx]) begin
                    state_d = StFlushWb;
                end else begin
                    scan_d = scan_q + (IDX_W+1)'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            scan_q      <= '0;
            miss_line_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            miss_line_q <= miss_line_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    // Line storage carries no reset; valid_q gates every use of it.
    always_ff @(posedge CLK) begin
        if (store_en) begin
            data_q[req_idx] <= store_line;
        end
        if (fill_en) begin
            data_q[miss_idx] <= block_read_fDM;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

endmodule
